// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the uc_ctrl control unit.
// Holds the opcode constants, condition encodings, the FSM state enum,
// the ALUOp width and the branch/skip condition helper.
package uc_pkg;

  localparam int ALUOP_W = 3;

  // Opcode prefixes and full opcodes (instruction[15:10])
  localparam logic [1:0] OP_ALU_PFX = 2'b00;
  localparam logic [3:0] OP_LI_PFX  = 4'b0100;
  localparam logic [5:0] OP_J       = 6'b100000;
  localparam logic [5:0] OP_JZ      = 6'b100001;
  localparam logic [5:0] OP_JNZ     = 6'b100010;
  localparam logic [5:0] OP_JC      = 6'b100011;
  localparam logic [5:0] OP_JNC     = 6'b100100;
  localparam logic [5:0] OP_SKZ     = 6'b101000;
  localparam logic [5:0] OP_SKNZ    = 6'b101001;
  localparam logic [5:0] OP_SKC     = 6'b101010;
  localparam logic [5:0] OP_SKNC    = 6'b101011;
  localparam logic [5:0] OP_NOP     = 6'b111111;

  // Condition encoding: bit 1 selects the flag (0 = Z, 1 = C), bit 0 inverts it
  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_C  = 2'b10;
  localparam logic [1:0] COND_NC = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } uc_state_e;

  // Evaluate a condition code against the latched flags
  function automatic logic cond_met(input logic [1:0] cond, input logic z, input logic c);
    logic f;
    f = cond[1] ? c : z;
    return cond[0] ? ~f : f;
  endfunction

endpackage

// File: rtl/uc_ctrl_if.sv
// uc_ctrl_if: datapath <-> control unit signal bundle.
// master = datapath side (drives opcode and ALU status),
// slave  = uc_ctrl side (drives the control strobes and flag view).
interface uc_ctrl_if;
  import uc_pkg::*;

  logic [5:0]         Opcode;
  logic               zero;
  logic               carry;
  logic               s_skip;
  logic               s_inc;
  logic               s_inm;
  logic               we;
  logic [ALUOP_W-1:0] ALUOp;
  logic               flag_z;
  logic               flag_c;
  logic               slot_valid;

  modport master (
    output Opcode, zero, carry,
    input  s_skip, s_inc, s_inm, we, ALUOp, flag_z, flag_c, slot_valid
  );

  modport slave (
    input  Opcode, zero, carry,
    output s_skip, s_inc, s_inm, we, ALUOp, flag_z, flag_c, slot_valid
  );

endinterface

// File: rtl/uc_decode.sv
// uc_decode: purely combinational opcode classifier.
// Undefined opcodes decode to nothing (all flags low), i.e. a NOP.
// br_uncond marks the unconditional jump, which has no condition code.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0]         opcode,
  output logic               is_alu,
  output logic               is_li,
  output logic               is_br,
  output logic               is_skip,
  output logic               br_uncond,
  output logic [1:0]         cond,
  output logic [ALUOP_W-1:0] alu_op
);

  // Classify the opcode into instruction class, condition and ALU operation
  always_comb begin
    is_alu    = 1'b0;
    is_li     = 1'b0;
    is_br     = 1'b0;
    is_skip   = 1'b0;
    br_uncond = 1'b0;
    cond      = COND_Z;
    alu_op    = '0;
    if (opcode[5:4] == OP_ALU_PFX) begin
      is_alu = 1'b1;
      alu_op = opcode[3:1];
    end else if (opcode[5:2] == OP_LI_PFX) begin
      is_li = 1'b1;
    end else begin
      case (opcode)
        OP_J:    begin is_br = 1'b1; br_uncond = 1'b1; end
        OP_JZ:   begin is_br = 1'b1; cond = COND_Z;  end
        OP_JNZ:  begin is_br = 1'b1; cond = COND_NZ; end
        OP_JC:   begin is_br = 1'b1; cond = COND_C;  end
        OP_JNC:  begin is_br = 1'b1; cond = COND_NC; end
        OP_SKZ:  begin is_skip = 1'b1; cond = COND_Z;  end
        OP_SKNZ: begin is_skip = 1'b1; cond = COND_NZ; end
        OP_SKC:  begin is_skip = 1'b1; cond = COND_C;  end
        OP_SKNC: begin is_skip = 1'b1; cond = COND_NC; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uc_ctrl.sv
// uc_ctrl: microcontroller control unit.
// Program memory is read synchronously, so the slot after a taken branch
// or skip already holds a stale instruction; the FSM annuls that slot.
// Branch/skip conditions use the latched Z/C flags, never the live ALU status.
// Optional build macro UC_PERF_CNT_EN adds saturating retired/annulled counters.
module uc_ctrl
  import uc_pkg::*;
#(
  parameter int STARTUP_BUBBLES = 1,
  parameter bit LI_CLEARS_FLAGS = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  uc_ctrl_if.slave    bus
`ifdef UC_PERF_CNT_EN
  ,
  output logic [15:0] retired,
  output logic [15:0] annulled
`endif
);

  localparam logic [1:0] BOOT_LAST = 2'(STARTUP_BUBBLES - 1);

  uc_state_e          state, state_nxt;
  logic [1:0]         boot_cnt, boot_cnt_nxt;
  logic               flag_z, flag_c;

  logic               is_alu, is_li, is_br, is_skip, br_uncond;
  logic [1:0]         cond;
  logic [ALUOP_W-1:0] alu_op;

  logic               slot_valid;
  logic               s_skip, s_inc, s_inm, we;
  logic [ALUOP_W-1:0] alu_op_out;
  logic               cond_ok;

  uc_decode u_decode (
    .opcode    (bus.Opcode),
    .is_alu    (is_alu),
    .is_li     (is_li),
    .is_br     (is_br),
    .is_skip   (is_skip),
    .br_uncond (br_uncond),
    .cond      (cond),
    .alu_op    (alu_op)
  );

  assign cond_ok = cond_met(cond, flag_z, flag_c);

  // State register and startup bubble counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      boot_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
    end
  end

  // Next-state and combinational control outputs
  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    slot_valid   = 1'b0;
    s_skip       = 1'b0;
    s_inc        = 1'b0;
    s_inm        = 1'b0;
    we           = 1'b0;
    alu_op_out   = '0;
    case (state)
      ST_BOOT: begin
        if (boot_cnt == BOOT_LAST) begin
          state_nxt    = ST_RUN;
          boot_cnt_nxt = 2'd0;
        end else begin
          boot_cnt_nxt = boot_cnt + 2'd1;
        end
      end
      ST_RUN: begin
        slot_valid = 1'b1;
        we         = is_alu | is_li;
        s_inm      = is_li;
        alu_op_out = is_alu ? alu_op : '0;
        s_inc      = is_br & (br_uncond | cond_ok);
        s_skip     = is_skip & cond_ok;
        if (s_inc || s_skip) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Stale slot: everything stays at its inactive default, PC goes +1
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Architectural flag register, updated only by executed ALU ops (and LI if configured)
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (slot_valid && is_alu) begin
      flag_z <= bus.zero;
      flag_c <= bus.carry;
    end else if (slot_valid && is_li && LI_CLEARS_FLAGS) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end
  end

  assign bus.slot_valid = slot_valid;
  assign bus.s_skip     = s_skip;
  assign bus.s_inc      = s_inc;
  assign bus.s_inm      = s_inm;
  assign bus.we         = we;
  assign bus.ALUOp      = alu_op_out;
  assign bus.flag_z     = flag_z;
  assign bus.flag_c     = flag_c;

`ifdef UC_PERF_CNT_EN
  // Saturating counters of executed and squashed slots
  always_ff @(posedge clk) begin
    if (reset) begin
      retired  <= 16'd0;
      annulled <= 16'd0;
    end else if (slot_valid) begin
      if (retired != 16'hFFFF) retired <= retired + 16'd1;
    end else begin
      if (annulled != 16'hFFFF) annulled <= annulled + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uc_ctrl.sv
// tb_uc_ctrl: directed self-checking bench for uc_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uc_ctrl;
  import uc_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  uc_ctrl_if bus ();

`ifdef UC_PERF_CNT_EN
  logic [15:0] retired;
  logic [15:0] annulled;
`endif

  uc_ctrl #(.STARTUP_BUBBLES(1), .LI_CLEARS_FLAGS(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave)
`ifdef UC_PERF_CNT_EN
    ,
    .retired  (retired),
    .annulled (annulled)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic c);
    @(negedge clk);
    bus.Opcode = op;
    bus.zero   = z;
    bus.carry  = c;
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.Opcode = OP_NOP;
    bus.zero   = 1'b0;
    bus.carry  = 1'b0;
    repeat (2) @(negedge clk);

    // Startup bubble: ALU op with zero/carry high must be squashed
    reset      = 1'b0;
    bus.Opcode = 6'b000110;
    bus.zero   = 1'b1;
    bus.carry  = 1'b1;
    #1;
    chk("boot_valid", 16'(bus.slot_valid), 16'd0);
    chk("boot_we", 16'(bus.we), 16'd0);
    chk("boot_aluop", 16'(bus.ALUOp), 16'd0);
    chk("boot_sinc", 16'(bus.s_inc), 16'd0);
    chk("boot_sskip", 16'(bus.s_skip), 16'd0);
    chk("rst_flagz", 16'(bus.flag_z), 16'd0);
    chk("rst_flagc", 16'(bus.flag_c), 16'd0);

    drive(OP_NOP, 1'b0, 1'b0);
    chk("run_valid", 16'(bus.slot_valid), 16'd1);
    chk("nop_we", 16'(bus.we), 16'd0);
    chk("boot_noflag", 16'({bus.flag_z, bus.flag_c}), 16'd0);

    // ALU op 011 with zero=carry=1
    drive(6'b000110, 1'b1, 1'b1);
    chk("alu_op", 16'(bus.ALUOp), 16'd3);
    chk("alu_we", 16'(bus.we), 16'd1);
    chk("alu_sinm", 16'(bus.s_inm), 16'd0);
    drive(OP_NOP, 1'b0, 1'b0);
    chk("alu_flags", 16'({bus.flag_z, bus.flag_c}), 16'b11);

    // JZ taken, then annulled ALU op must not write or touch flags
    drive(OP_JZ, 1'b0, 1'b0);
    chk("jz_sinc", 16'(bus.s_inc), 16'd1);
    chk("jz_sskip", 16'(bus.s_skip), 16'd0);
    drive(6'b000110, 1'b0, 1'b0);
    chk("flush_valid", 16'(bus.slot_valid), 16'd0);
    chk("flush_we", 16'(bus.we), 16'd0);
    chk("flush_aluop", 16'(bus.ALUOp), 16'd0);
    drive(OP_NOP, 1'b0, 1'b0);
    chk("post_flush_valid", 16'(bus.slot_valid), 16'd1);
    chk("flush_flags", 16'({bus.flag_z, bus.flag_c}), 16'b11);

    // ALU op 001 with zero=0 carry=1 -> Z=0, C=1
    drive(6'b000010, 1'b0, 1'b1);
    chk("alu1_op", 16'(bus.ALUOp), 16'd1);
    drive(OP_SKNZ, 1'b0, 1'b0);
    chk("sknz_flags", 16'({bus.flag_z, bus.flag_c}), 16'b01);
    chk("sknz_sskip", 16'(bus.s_skip), 16'd1);
    chk("sknz_sinc", 16'(bus.s_inc), 16'd0);
    drive(6'b000100, 1'b1, 1'b0);
    chk("skip_annul_valid", 16'(bus.slot_valid), 16'd0);
    chk("skip_annul_we", 16'(bus.we), 16'd0);
    drive(OP_NOP, 1'b0, 1'b0);
    chk("skip_flags", 16'({bus.flag_z, bus.flag_c}), 16'b01);

    // LI: immediate write, flags untouched with LI_CLEARS_FLAGS=0
    drive(6'b010011, 1'b1, 1'b1);
    chk("li_we", 16'(bus.we), 16'd1);
    chk("li_sinm", 16'(bus.s_inm), 16'd1);
    chk("li_aluop", 16'(bus.ALUOp), 16'd0);
    drive(OP_NOP, 1'b0, 1'b0);
    chk("li_flags", 16'({bus.flag_z, bus.flag_c}), 16'b01);

    // Not-taken conditionals: no redirect, no annulment
    drive(OP_JZ, 1'b0, 1'b0);
    chk("jz_nt_sinc", 16'(bus.s_inc), 16'd0);
    drive(OP_SKNC, 1'b0, 1'b0);
    chk("sknc_nt_sskip", 16'(bus.s_skip), 16'd0);
    drive(6'b011000, 1'b0, 1'b0);
    chk("nt_next_valid", 16'(bus.slot_valid), 16'd1);
    chk("undef_we", 16'(bus.we), 16'd0);

    // Clear C, then J; JNC in annulled slot ignored; JNC right after flush taken
    drive(6'b000000, 1'b0, 1'b0);
    chk("alu0_we", 16'(bus.we), 16'd1);
    drive(OP_J, 1'b0, 1'b0);
    chk("j_sinc", 16'(bus.s_inc), 16'd1);
    drive(OP_JNC, 1'b0, 1'b0);
    chk("jnc_annul_sinc", 16'(bus.s_inc), 16'd0);
    chk("jnc_annul_valid", 16'(bus.slot_valid), 16'd0);
    drive(OP_JNC, 1'b0, 1'b0);
    chk("jnc_taken_sinc", 16'(bus.s_inc), 16'd1);
    drive(OP_JNC, 1'b0, 1'b0);
    chk("jnc2_annul_sinc", 16'(bus.s_inc), 16'd0);
    drive(OP_SKC, 1'b0, 1'b0);
    chk("skc_nt_sskip", 16'(bus.s_skip), 16'd0);

    // Set flags, take a branch, then assert reset during the flush slot
    drive(6'b001110, 1'b1, 1'b1);
    drive(OP_J, 1'b0, 1'b0);
    chk("j2_flags", 16'({bus.flag_z, bus.flag_c}), 16'b11);
    chk("j2_sinc", 16'(bus.s_inc), 16'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midflush_rst_valid", 16'(bus.slot_valid), 16'd0);
    chk("midflush_rst_flags", 16'({bus.flag_z, bus.flag_c}), 16'b00);
    reset = 1'b0;
    #1;
    chk("rst_boot_valid", 16'(bus.slot_valid), 16'd0);
    drive(OP_NOP, 1'b0, 1'b0);
    chk("rst_run_valid", 16'(bus.slot_valid), 16'd1);

`ifdef UC_PERF_CNT_EN
    // Counters: 1 boot bubble + J + flush + 4 NOPs -> retired 5, annulled 2
    @(negedge clk);
    reset      = 1'b1;
    bus.Opcode = OP_NOP;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cnt_rst_ret", retired, 16'd0);
    chk("cnt_rst_ann", annulled, 16'd0);
    drive(OP_J, 1'b0, 1'b0);
    drive(OP_NOP, 1'b0, 1'b0);
    repeat (4) drive(OP_NOP, 1'b0, 1'b0);
    drive(OP_NOP, 1'b0, 1'b0);
    chk("cnt_retired", retired, 16'd5);
    chk("cnt_annulled", annulled, 16'd2);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("cnt_clr_ret", retired, 16'd0);
    chk("cnt_clr_ann", annulled, 16'd0);
    reset = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
